math_core: RTL and testbench

- Parametrised successor to the single-pair byte-serial accumulator unit.
- Holds NUM_ACC accumulators of BITS width, addressed by explicit destination/source selects.
- Adds subtraction, move, compare, status flags, non-destructive byte-serial readback, and an optional multi-cycle shift-add multiplier with a busy indication.
- Sits behind the 8-bit data/op pins of the top-level project wrapper.

---
 rtl/math_core.sv | 243 ++++++++++++++++++++++++
 tb/tb_math_core.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/math_core.sv
// Multi-accumulator byte-serial arithmetic core with flags and readback.
// Optional shift-add multiplier enabled by defining MATH_CORE_MUL_EN.
module math_core #(
  parameter int BITS    = 64,
  parameter int NUM_ACC = 4,
  localparam int SELW   = $clog2(NUM_ACC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      op_in,
  input  logic [SELW-1:0] dst_sel,
  input  logic [SELW-1:0] src_sel,
  input  logic [7:0]      data_in,
  output logic [7:0]      data_out,
  output logic            carry,
  output logic            zero,
  output logic            busy
);

  localparam logic [3:0] OP_CLR  = 4'h1;
  localparam logic [3:0] OP_LOAD = 4'h2;
  localparam logic [3:0] OP_READ = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_CMP  = 4'hB;

  logic [BITS-1:0] acc_r [NUM_ACC];
  logic [BITS-1:0] dst_v_s, src_v_s;
  logic [BITS:0]   sum_s, diff_s, addi_s, shl_s, shr_s;
  logic            shift_big_s;

  logic            wr_en_s;
  logic [SELW-1:0] wr_sel_s;
  logic [BITS-1:0] wr_val_s;
  logic            flag_en_s;
  logic            carry_s;
  logic [BITS-1:0] res_s;
  logic            rd_en_s;
  logic            busy_s;

  logic            mul_done_s;
  logic [BITS-1:0] mul_lo_s;
  logic            mul_hi_nz_s;
  logic [SELW-1:0] mul_dst_s;

  assign dst_v_s     = acc_r[dst_sel];
  assign src_v_s     = acc_r[src_sel];
  assign sum_s       = {1'b0, dst_v_s} + {1'b0, src_v_s};
  assign diff_s      = {1'b0, dst_v_s} - {1'b0, src_v_s};
  assign addi_s      = {1'b0, dst_v_s} + {{(BITS-7){1'b0}}, data_in};
  // Extra bit on the shifted-out side captures the last bit lost.
  assign shl_s       = {1'b0, src_v_s} << data_in;
  assign shr_s       = {src_v_s, 1'b0} >> data_in;
  assign shift_big_s = (32'(data_in) >= 32'(BITS));
  assign busy        = busy_s;

`ifdef MATH_CORE_MUL_EN
  localparam int CNTW = $clog2(BITS);

  typedef enum logic {M_IDLE, M_RUN} mstate_t;

  mstate_t           state_r, state_nx_s;
  logic [2*BITS-1:0] mcand_r, prod_r, prod_add_s;
  logic [BITS-1:0]   mplier_r;
  logic [CNTW-1:0]   cnt_r;
  logic [SELW-1:0]   mdst_r;
  logic              mul_start_s;

  assign busy_s      = (state_r == M_RUN);
  assign prod_add_s  = mplier_r[0] ? (prod_r + mcand_r) : prod_r;
  assign mul_done_s  = busy_s && (cnt_r == CNTW'(BITS-1));
  assign mul_lo_s    = prod_add_s[BITS-1:0];
  assign mul_hi_nz_s = |prod_add_s[2*BITS-1:BITS];
  assign mul_dst_s   = mdst_r;

  // Multiplier next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      M_IDLE:  if (mul_start_s) state_nx_s = M_RUN; else state_nx_s = M_IDLE;
      M_RUN:   if (mul_done_s) state_nx_s = M_IDLE; else state_nx_s = M_RUN;
      default: state_nx_s = M_IDLE;
    endcase
  end

  // Multiplier state and datapath: one multiplier bit per busy cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= M_IDLE;
      mcand_r  <= '0;
      prod_r   <= '0;
      mplier_r <= '0;
      cnt_r    <= '0;
      mdst_r   <= '0;
    end else begin
      state_r <= state_nx_s;
      if (mul_start_s) begin
        mcand_r  <= {{BITS{1'b0}}, dst_v_s};
        mplier_r <= src_v_s;
        prod_r   <= '0;
        cnt_r    <= '0;
        mdst_r   <= dst_sel;
      end else if (busy_s) begin
        prod_r   <= prod_add_s;
        mcand_r  <= mcand_r << 1;
        mplier_r <= mplier_r >> 1;
        cnt_r    <= cnt_r + CNTW'(1);
      end
    end
  end
`else
  assign busy_s      = 1'b0;
  assign mul_done_s  = 1'b0;
  assign mul_lo_s    = '0;
  assign mul_hi_nz_s = 1'b0;
  assign mul_dst_s   = '0;
`endif

  // Opcode decode: selects the single accumulator write and flag update.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_sel_s  = dst_sel;
    wr_val_s  = dst_v_s;
    flag_en_s = 1'b0;
    carry_s   = carry;
    res_s     = '0;
    rd_en_s   = 1'b0;
`ifdef MATH_CORE_MUL_EN
    mul_start_s = 1'b0;
`endif
    if (mul_done_s) begin
      wr_en_s   = 1'b1;
      wr_sel_s  = mul_dst_s;
      wr_val_s  = mul_lo_s;
      flag_en_s = 1'b1;
      carry_s   = mul_hi_nz_s;
      res_s     = mul_lo_s;
    end else if (!busy_s) begin
      case (op_in)
        OP_CLR: begin
          wr_en_s  = 1'b1;
          wr_val_s = '0;
        end
        OP_LOAD: begin
          wr_en_s  = 1'b1;
          wr_val_s = {dst_v_s[BITS-9:0], data_in};
        end
        OP_READ: begin
          rd_en_s  = 1'b1;
          wr_en_s  = 1'b1;
          wr_sel_s = src_sel;
          wr_val_s = {src_v_s[7:0], src_v_s[BITS-1:8]};
        end
        OP_ADD: begin
          wr_en_s   = 1'b1;
          wr_val_s  = sum_s[BITS-1:0];
          flag_en_s = 1'b1;
          carry_s   = sum_s[BITS];
          res_s     = sum_s[BITS-1:0];
        end
        OP_SUB: begin
          wr_en_s   = 1'b1;
          wr_val_s  = diff_s[BITS-1:0];
          flag_en_s = 1'b1;
          carry_s   = diff_s[BITS];
          res_s     = diff_s[BITS-1:0];
        end
        OP_ADDI: begin
          wr_en_s   = 1'b1;
          wr_val_s  = addi_s[BITS-1:0];
          flag_en_s = 1'b1;
          carry_s   = addi_s[BITS];
          res_s     = addi_s[BITS-1:0];
        end
        OP_MOV: begin
          wr_en_s  = 1'b1;
          wr_val_s = src_v_s;
        end
        OP_SHL: begin
          wr_en_s   = 1'b1;
          flag_en_s = 1'b1;
          if (shift_big_s) begin
            res_s   = '0;
            carry_s = 1'b0;
          end else begin
            res_s   = shl_s[BITS-1:0];
            carry_s = shl_s[BITS];
          end
          wr_val_s = res_s;
        end
        OP_SHR: begin
          wr_en_s   = 1'b1;
          flag_en_s = 1'b1;
          if (shift_big_s) begin
            res_s   = '0;
            carry_s = 1'b0;
          end else begin
            res_s   = shr_s[BITS:1];
            carry_s = shr_s[0];
          end
          wr_val_s = res_s;
        end
        OP_MUL: begin
`ifdef MATH_CORE_MUL_EN
          mul_start_s = 1'b1;
`endif
        end
        OP_CMP: begin
          flag_en_s = 1'b1;
          carry_s   = diff_s[BITS];
          res_s     = diff_s[BITS-1:0];
        end
        default: begin
        end
      endcase
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Accumulator file, readback byte and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACC; i++) acc_r[i] <= '0;
      data_out <= 8'h00;
      carry    <= 1'b0;
      zero     <= 1'b1;
    end else begin
      if (wr_en_s) acc_r[wr_sel_s] <= wr_val_s;
      if (rd_en_s) data_out <= src_v_s[7:0];
      if (flag_en_s) begin
        carry <= carry_s;
        zero  <= (res_s == '0);
      end
    end
  end

endmodule

// File: tb/tb_math_core.sv
// Directed self-checking bench for math_core (BITS=64, NUM_ACC=4).
module tb_math_core;

  localparam logic [3:0] NOP  = 4'h0;
  localparam logic [3:0] CLR  = 4'h1;
  localparam logic [3:0] LOAD = 4'h2;
  localparam logic [3:0] READ = 4'h3;
  localparam logic [3:0] ADD  = 4'h4;
  localparam logic [3:0] SUB  = 4'h5;
  localparam logic [3:0] ADDI = 4'h6;
  localparam logic [3:0] MOV  = 4'h7;
  localparam logic [3:0] SHL  = 4'h8;
  localparam logic [3:0] SHR  = 4'h9;
  localparam logic [3:0] MUL  = 4'hA;
  localparam logic [3:0] CMP  = 4'hB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] op_in = 4'h0;
  logic [1:0] dst_sel = 2'd0;
  logic [1:0] src_sel = 2'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       carry, zero, busy;

  int checks = 0;
  int errors = 0;
  logic [63:0] v;
  int bcnt;

  math_core #(.BITS(64), .NUM_ACC(4)) dut (
    .clk(clk), .rst(rst), .op_in(op_in), .dst_sel(dst_sel), .src_sel(src_sel),
    .data_in(data_in), .data_out(data_out), .carry(carry), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one op for one edge, leave NOP driven afterwards.
  task automatic step(input logic [3:0] op, input logic [1:0] d, input logic [1:0] s,
                      input logic [7:0] b);
    @(negedge clk);
    op_in = op; dst_sel = d; src_sel = s; data_in = b;
    @(posedge clk);
    #1;
    op_in = NOP;
  endtask

  task automatic load_word(input logic [1:0] sel, input logic [63:0] w);
    step(CLR, sel, 2'd0, 8'h00);
    for (int i = 7; i >= 0; i--) step(LOAD, sel, 2'd0, w[8*i +: 8]);
  endtask

  task automatic read_acc(input logic [1:0] sel, output logic [63:0] w);
    w = 64'd0;
    for (int i = 0; i < 8; i++) begin
      step(READ, 2'd0, sel, 8'h00);
      w[8*i +: 8] = data_out;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_data_out", {56'd0, data_out}, 64'h00);
    chk("rst_zero", {63'd0, zero}, 64'd1);
    chk("rst_carry", {63'd0, carry}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    step(READ, 2'd0, 2'd0, 8'h00);
    chk("read_acc0", {56'd0, data_out}, 64'h00);

    for (int i = 1; i <= 8; i++) step(LOAD, 2'd1, 2'd0, 8'(i));
    for (int i = 0; i < 8; i++) begin
      step(READ, 2'd0, 2'd1, 8'h00);
      chk($sformatf("read_byte%0d", i), {56'd0, data_out}, 64'(8 - i));
    end
    read_acc(2'd1, v);
    chk("acc1_restored", v, 64'h0102030405060708);

    load_word(2'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    step(ADDI, 2'd0, 2'd3, 8'h01);
    chk("addi_carry", {63'd0, carry}, 64'd1);
    chk("addi_zero", {63'd0, zero}, 64'd1);
    read_acc(2'd0, v);
    chk("addi_acc0", v, 64'd0);
    load_word(2'd2, 64'd5);
    step(SUB, 2'd0, 2'd2, 8'h00);
    chk("sub_carry", {63'd0, carry}, 64'd1);
    chk("sub_zero", {63'd0, zero}, 64'd0);
    read_acc(2'd0, v);
    chk("sub_acc0", v, 64'hFFFF_FFFF_FFFF_FFFB);

    load_word(2'd3, 64'h8000_0000_0000_0001);
    step(SHL, 2'd2, 2'd3, 8'd1);
    chk("shl1_carry", {63'd0, carry}, 64'd1);
    chk("shl1_zero", {63'd0, zero}, 64'd0);
    read_acc(2'd2, v);
    chk("shl1_acc2", v, 64'h2);
    step(SHL, 2'd2, 2'd3, 8'd64);
    chk("shl64_carry", {63'd0, carry}, 64'd0);
    chk("shl64_zero", {63'd0, zero}, 64'd1);
    read_acc(2'd2, v);
    chk("shl64_acc2", v, 64'd0);
    step(SHR, 2'd2, 2'd3, 8'd0);
    chk("shr0_carry", {63'd0, carry}, 64'd0);
    chk("shr0_zero", {63'd0, zero}, 64'd0);
    read_acc(2'd2, v);
    chk("shr0_acc2", v, 64'h8000_0000_0000_0001);
    step(SHR, 2'd2, 2'd3, 8'd1);
    chk("shr1_carry", {63'd0, carry}, 64'd1);
    read_acc(2'd2, v);
    chk("shr1_acc2", v, 64'h4000_0000_0000_0000);

    load_word(2'd3, 64'd7);
    load_word(2'd1, 64'd7);
    step(CMP, 2'd3, 2'd1, 8'h00);
    chk("cmp_zero", {63'd0, zero}, 64'd1);
    chk("cmp_carry", {63'd0, carry}, 64'd0);
    read_acc(2'd3, v);
    chk("cmp_acc3", v, 64'd7);
    step(ADD, 2'd3, 2'd3, 8'h00);
    chk("add_self_zero", {63'd0, zero}, 64'd0);
    read_acc(2'd3, v);
    chk("add_self_acc3", v, 64'd14);
    step(MOV, 2'd0, 2'd3, 8'h00);
    read_acc(2'd0, v);
    chk("mov_acc0", v, 64'd14);
    step(CMP, 2'd1, 2'd3, 8'h00);
    chk("cmp_borrow", {63'd0, carry}, 64'd1);
    chk("cmp_nz", {63'd0, zero}, 64'd0);

`ifdef MATH_CORE_MUL_EN
    load_word(2'd0, 64'h1_0000_0000);
    load_word(2'd1, 64'h1_0000_0000);
    step(MUL, 2'd0, 2'd1, 8'h00);
    bcnt = 0;
    while (busy === 1'b1 && bcnt < 200) begin
      bcnt++;
      if (bcnt == 5) begin
        op_in = CLR; dst_sel = 2'd1;
      end
      @(posedge clk);
      #1;
      op_in = NOP;
    end
    chk("mul_busy_cycles", 64'(bcnt), 64'd64);
    chk("mul_carry", {63'd0, carry}, 64'd1);
    chk("mul_zero", {63'd0, zero}, 64'd1);
    read_acc(2'd0, v);
    chk("mul_acc0", v, 64'd0);
    read_acc(2'd1, v);
    chk("mul_drop_acc1", v, 64'h1_0000_0000);
    step(MUL, 2'd0, 2'd1, 8'h00);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("mul_mid_busy", {63'd0, busy}, 64'd1);
    do_reset();
    chk("mul_rst_busy", {63'd0, busy}, 64'd0);
`else
    step(MUL, 2'd0, 2'd3, 8'h00);
    chk("nomul_busy", {63'd0, busy}, 64'd0);
    chk("nomul_carry", {63'd0, carry}, 64'd1);
    chk("nomul_zero", {63'd0, zero}, 64'd0);
    read_acc(2'd0, v);
    chk("nomul_acc0", v, 64'd14);
    do_reset();
`endif
    chk("end_rst_zero", {63'd0, zero}, 64'd1);
    for (int a = 0; a < 4; a++) begin
      read_acc(2'(a), v);
      chk($sformatf("end_rst_acc%0d", a), v, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
